// File: rtl/encoder_frontend.sv
// Quadrature encoder front end: pad synchroniser, prescaled debounce, detent
// decode and a saturating or wrapping brightness counter with step strobes.
module encoder_frontend #(
  parameter int WIDTH       = 8,
  parameter int DIV         = 1000,
  parameter int LEN         = 4,
  parameter int STEP        = 1,
  parameter int SATURATE    = 1,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  output logic [WIDTH-1:0] value,
  output logic             step_up,
  output logic             step_dn,
  output logic             ready
);

  localparam int             DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0]  DIV_LAST = DW'(DIV - 1);
  localparam logic [WIDTH:0] STEP_X   = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] RST_V  = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] MAX_V  = {WIDTH{1'b1}};

  logic             a_s1_q, a_s1_d, a_sync_q, a_sync_d;
  logic             b_s1_q, b_s1_d, b_sync_q, b_sync_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic [LEN-1:0]   a_hist_q, a_hist_d, b_hist_q, b_hist_d;
  logic             loaded_q, loaded_d;
  logic             a_db_q, a_db_d, b_db_q, b_db_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             step_up_q, step_up_d, step_dn_q, step_dn_d;

  logic             tick_s, a_db_nx_s, b_db_nx_s, rise_s;
  logic [WIDTH:0]   sum_up_s, sum_dn_s;

  // A level is accepted only once the whole sample window agrees on it.
  function automatic logic db_next(input logic [LEN-1:0] hist, input logic cur);
    if (&hist) begin
      return 1'b1;
    end else if (~|hist) begin
      return 1'b0;
    end else begin
      return cur;
    end
  endfunction

  // Next-state logic for synchroniser, prescaler, debounce and counter.
  always_comb begin
    a_s1_d    = enc_a;
    a_sync_d  = a_s1_q;
    b_s1_d    = enc_b;
    b_sync_d  = b_s1_q;
    a_hist_d  = a_hist_q;
    b_hist_d  = b_hist_q;
    loaded_d  = loaded_q;
    a_db_d    = a_db_q;
    b_db_d    = b_db_q;
    value_d   = value_q;
    step_up_d = 1'b0;
    step_dn_d = 1'b0;

    tick_s    = (div_cnt_q == DIV_LAST);
    div_cnt_d = tick_s ? {DW{1'b0}} : div_cnt_q + DW'(1);

    a_db_nx_s = db_next(a_hist_q, a_db_q);
    b_db_nx_s = db_next(b_hist_q, b_db_q);
    rise_s    = loaded_q & a_db_nx_s & ~a_db_q;
    sum_up_s  = {1'b0, value_q} + STEP_X;
    sum_dn_s  = {1'b0, value_q} - STEP_X;

    if (loaded_q) begin
      a_db_d = a_db_nx_s;
      b_db_d = b_db_nx_s;
    end else begin
      a_db_d = a_db_q;
      b_db_d = b_db_q;
    end

    // Direction uses the B level already debounced, not the one updating now.
    if (rise_s) begin
      if (!b_db_q) begin
        step_up_d = 1'b1;
        if ((SATURATE != 0) && sum_up_s[WIDTH]) begin
          value_d = MAX_V;
        end else begin
          value_d = sum_up_s[WIDTH-1:0];
        end
      end else begin
        step_dn_d = 1'b1;
        if ((SATURATE != 0) && sum_dn_s[WIDTH]) begin
          value_d = {WIDTH{1'b0}};
        end else begin
          value_d = sum_dn_s[WIDTH-1:0];
        end
      end
    end else begin
      value_d = value_q;
    end

    // First tick seeds the history from the pins so power-up levels make no step.
    if (tick_s) begin
      if (!loaded_q) begin
        a_hist_d = {LEN{a_sync_q}};
        b_hist_d = {LEN{b_sync_q}};
        a_db_d   = a_sync_q;
        b_db_d   = b_sync_q;
        loaded_d = 1'b1;
      end else begin
        a_hist_d = {a_hist_q[LEN-2:0], a_sync_q};
        b_hist_d = {b_hist_q[LEN-2:0], b_sync_q};
      end
    end else begin
      a_hist_d = a_hist_q;
      b_hist_d = b_hist_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_s1_q    <= 1'b0;
      a_sync_q  <= 1'b0;
      b_s1_q    <= 1'b0;
      b_sync_q  <= 1'b0;
      div_cnt_q <= {DW{1'b0}};
      a_hist_q  <= {LEN{1'b0}};
      b_hist_q  <= {LEN{1'b0}};
      loaded_q  <= 1'b0;
      a_db_q    <= 1'b0;
      b_db_q    <= 1'b0;
      value_q   <= RST_V;
      step_up_q <= 1'b0;
      step_dn_q <= 1'b0;
    end else begin
      a_s1_q    <= a_s1_d;
      a_sync_q  <= a_sync_d;
      b_s1_q    <= b_s1_d;
      b_sync_q  <= b_sync_d;
      div_cnt_q <= div_cnt_d;
      a_hist_q  <= a_hist_d;
      b_hist_q  <= b_hist_d;
      loaded_q  <= loaded_d;
      a_db_q    <= a_db_d;
      b_db_q    <= b_db_d;
      value_q   <= value_d;
      step_up_q <= step_up_d;
      step_dn_q <= step_dn_d;
    end
  end

  assign value   = value_q;
  assign step_up = step_up_q;
  assign step_dn = step_dn_q;
  assign ready   = loaded_q;

endmodule

// File: tb/tb_encoder_frontend.sv
// Directed bench for encoder_frontend: one general instance plus three
// saturation/wrap instances, all with DIV=4, LEN=3.
module tb_encoder_frontend;

  logic       clk = 1'b0;
  logic       reset;
  logic       a0, b0, ga, gb_up, gb_dn;
  logic [7:0] value0, value1, value2, value3;
  logic       up0, dn0, up1, dn1, up2, dn2, up3, dn3;
  logic       ready0, ready1, ready2, ready3;

  int n_cmp = 0;
  int n_bad = 0;
  int cu0 = 0, cd0 = 0, cu1 = 0, cd1 = 0, cu2 = 0, cd2 = 0, cu3 = 0, cd3 = 0;
  int lat;

  always #5 clk = ~clk;

  encoder_frontend #(.WIDTH(8), .DIV(4), .LEN(3), .STEP(1), .SATURATE(1), .RESET_VALUE(0)) d0 (
    .clk(clk), .reset(reset), .enc_a(a0), .enc_b(b0), .value(value0),
    .step_up(up0), .step_dn(dn0), .ready(ready0));
  encoder_frontend #(.WIDTH(8), .DIV(4), .LEN(3), .STEP(16), .SATURATE(1), .RESET_VALUE(250)) d1 (
    .clk(clk), .reset(reset), .enc_a(ga), .enc_b(gb_up), .value(value1),
    .step_up(up1), .step_dn(dn1), .ready(ready1));
  encoder_frontend #(.WIDTH(8), .DIV(4), .LEN(3), .STEP(16), .SATURATE(0), .RESET_VALUE(250)) d2 (
    .clk(clk), .reset(reset), .enc_a(ga), .enc_b(gb_up), .value(value2),
    .step_up(up2), .step_dn(dn2), .ready(ready2));
  encoder_frontend #(.WIDTH(8), .DIV(4), .LEN(3), .STEP(16), .SATURATE(1), .RESET_VALUE(5)) d3 (
    .clk(clk), .reset(reset), .enc_a(ga), .enc_b(gb_dn), .value(value3),
    .step_up(up3), .step_dn(dn3), .ready(ready3));

  task automatic check(input string tag, input int observed, input int expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One clock: sample on the falling edge and tally strobes.
  task automatic step();
    @(negedge clk);
    if (up0) cu0++;
    if (dn0) cd0++;
    if (up1) cu1++;
    if (dn1) cd1++;
    if (up2) cu2++;
    if (dn2) cd2++;
    if (up3) cu3++;
    if (dn3) cd3++;
    if (up0 || dn0) check("d0_excl", int'(up0 & dn0), 0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1; a0 = 1'b0; b0 = 1'b0; ga = 1'b1; gb_up = 1'b0; gb_dn = 1'b1;
    steps(3);
    check("rst_value0", int'(value0), 0);
    check("rst_ready0", int'(ready0), 0);
    check("rst_up0", int'(up0), 0);
    check("rst_dn0", int'(dn0), 0);
    check("rst_value1", int'(value1), 250);
    check("rst_value3", int'(value3), 5);
    check("rst_ready1", int'(ready1), 0);

    reset = 1'b0;
    steps(3);
    check("ready0_early", int'(ready0), 0);
    step();
    check("ready0_at4", int'(ready0), 1);
    check("ready1_at4", int'(ready1), 1);
    check("init_no_strobe0", cu0 + cd0, 0);

    steps(30);
    check("hi_init_strobes", cu1 + cd1 + cu2 + cd2 + cu3 + cd3, 0);
    check("hi_init_value1", int'(value1), 250);
    check("hi_init_value2", int'(value2), 250);
    check("hi_init_value3", int'(value3), 5);

    // Clockwise detent: bounded wait of 2 + LEN*DIV + 1 cycles.
    a0 = 1'b1;
    lat = 0;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (cu0 != 0) begin
        lat = i;
        break;
      end
    end
    check("cw_latency_ok", int'(lat >= 1 && lat <= 15), 1);
    check("cw_value", int'(value0), 1);
    steps(20);
    check("cw_single_up", cu0, 1);
    check("cw_no_dn", cd0, 0);

    a0 = 1'b0;
    steps(20);
    check("fall_no_up", cu0, 1);
    check("fall_no_dn", cd0, 0);
    check("fall_value", int'(value0), 1);

    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) a0 = ~a0;
      step();
    end
    check("bounce_quiet", cu0 + cd0, 1);
    a0 = 1'b1;
    steps(30);
    check("bounce_one_up", cu0, 2);
    check("bounce_value", int'(value0), 2);

    ga = 1'b0;
    steps(20);
    check("grp_fall_quiet", cu1 + cd1 + cu2 + cd2 + cu3 + cd3, 0);
    ga = 1'b1;
    steps(20);
    check("sat_up_value", int'(value1), 255);
    check("sat_up_strobe", cu1, 1);
    check("wrap_up_value", int'(value2), 10);
    check("wrap_up_strobe", cu2, 1);
    check("sat_dn_value", int'(value3), 0);
    check("sat_dn_strobe", cd3, 1);
    check("sat_dn_no_up", cu3, 0);
    ga = 1'b0;
    steps(20);
    ga = 1'b1;
    steps(20);
    check("sat_hold_value", int'(value1), 255);
    check("sat_hold_strobe", cu1, 2);
    check("sat_zero_value", int'(value3), 0);
    check("sat_zero_strobe", cd3, 2);
    check("wrap_second_value", int'(value2), 26);

    // Reset while the A history is only partly filled.
    a0 = 1'b0;
    steps(20);
    a0 = 1'b1;
    steps(8);
    check("mid_no_strobe", cu0, 2);
    reset = 1'b1;
    step();
    check("mid_rst_value", int'(value0), 0);
    check("mid_rst_ready", int'(ready0), 0);
    check("mid_rst_up", int'(up0), 0);
    reset = 1'b0;
    steps(30);
    check("mid_post_quiet", cu0 + cd0, 2);
    check("mid_post_ready", int'(ready0), 1);
    check("mid_post_value", int'(value0), 0);
    a0 = 1'b0;
    steps(20);
    a0 = 1'b1;
    steps(20);
    check("fresh_up", cu0, 3);
    check("fresh_value", int'(value0), 1);

    a0 = 1'b0;
    steps(20);
    b0 = 1'b1;
    steps(20);
    check("b_alone_quiet", cu0 + cd0, 3);
    a0 = 1'b1;
    steps(20);
    check("ccw_dn", cd0, 1);
    check("ccw_no_up", cu0, 3);
    check("ccw_value", int'(value0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/encoder_frontend.md
# encoder_frontend

Single-channel quadrature-encoder front end for the RGB mixer datapath. It takes one encoder's raw A/B pad inputs, synchronises and debounces them, decodes detents into up/down steps, and maintains a WIDTH-bit brightness value with one-cycle step strobes. The value feeds one PWM channel; three instances serve the red, green and blue channels.

## Interface
Parameters:
- WIDTH, 8: width of `value`.
- DIV, 1000: prescaler period in clk cycles between debounce samples (>=1).
- LEN, 4: consecutive agreeing samples required to change a debounced level (>=2).
- STEP, 1: amount added or subtracted per detent (1 .. 2^WIDTH-1).
- SATURATE, 1: 1 = clamp at 0 and 2^WIDTH-1; 0 = wrap modulo 2^WIDTH.
- RESET_VALUE, 0: `value` after reset.

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- enc_a  in  1  raw encoder A pad input, asynchronous.
- enc_b  in  1  raw encoder B pad input, asynchronous.
- value  out  WIDTH  current count, registered.
- step_up  out  1  one-cycle pulse per clockwise detent.
- step_dn  out  1  one-cycle pulse per counter-clockwise detent.
- ready  out  1  high once debounce state is initialised from the pins.

## Operation
- Synchroniser: two flops per input (a_s1->a_sync, b_s1->b_sync); reset 0.
- Prescaler: div_cnt counts 0..DIV-1 and wraps; tick = (div_cnt == DIV-1). Reset div_cnt = 0. DIV=1 gives tick every cycle.
- Sample history: LEN-bit shift registers a_hist, b_hist, reset 0. On tick, shift in a_sync/b_sync.
- Initialisation: `loaded` (drives `ready`) resets 0. At the first tick after reset: a_hist <= all a_sync, b_hist <= all b_sync, a_db <= a_sync, b_db <= b_sync, loaded <= 1. No step is generated at this edge.
- Debounce (loaded=1, every cycle): a_db_next = 1 if a_hist all ones, 0 if all zeros, else a_db. Same for b.
- Decode: detent when loaded and a_db_next=1 and a_db=0 (debounced A rising). Direction from current registered b_db: 0 -> up, 1 -> down. A falling edges and B edges alone produce nothing.
- Update, same edge as the a_db rise: up: value += STEP, step_up <= 1; down: value -= STEP, step_dn <= 1. step_up and step_dn never high together.
- SATURATE=1: value+STEP > 2^WIDTH-1 -> 2^WIDTH-1; value < STEP on down -> 0. Strobe still pulses when clamped (including already at the limit). SATURATE=0: modulo 2^WIDTH.
- Compute sums at WIDTH+1 bits before clamping; no intermediate truncation.
- Reset mid-operation: all state returns to reset values on that edge, pending detents discarded; re-initialisation repeats as above.

## Timing
- Reset values: value = RESET_VALUE, step_up = step_dn = 0, ready = 0, internal a_db = b_db = 0.
- ready rises at the edge of the first tick: DIV cycles after reset deasserts.
- Pin-to-value latency for a clean A rise (B stable, ready=1): 2 sync cycles, then LEN ticks for the new level to fill a_hist, then 1 cycle; bounded by 2 + LEN*DIV + 1 clk cycles.
- A level must appear in LEN consecutive tick samples to be accepted; any disagreeing sample holds the previous debounced level.
- Strobes are registered and last exactly one cycle; minimum spacing between strobes is 2*LEN ticks (A must fall and re-rise).
- Outputs change only on clk edges; no combinational input-to-output path.

## Test plan
- Reset, DIV=4, LEN=3, enc_a=enc_b=0: value=0, strobes 0, ready=0; ready=1 exactly 4 cycles after reset release; no strobe.
- Init with pins high: enc_a=enc_b=1 through reset -> ready rises, value stays RESET_VALUE, no strobe ever until a new A rise.
- Clockwise: B=0, A 0->1 held -> exactly one step_up pulse, value 0->1, within 2+3*4+1 = 15 cycles; A back to 0 -> no pulse.
- Bounce: A toggled every 3 cycles for 40 cycles, then held 1 -> exactly one step_up total.
- Saturation, WIDTH=8, STEP=16, RESET_VALUE=250: up -> value=255 with step_up; down from 5 -> value=0 with step_dn; SATURATE=0, value 250 up -> 10.
- Reset mid-operation: assert reset while A history is partially filled -> value=RESET_VALUE, ready=0 next cycle, no strobe after release until a fresh detent.
